mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width; array depth is 2^ADDR_W 16-bit words.
REQ-002 Parameter: VLEN, default 16, words per vector burst, giving a 256-bit vector.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-005 RD  input  1  read request level, held by the initiator until the matching done pulse.
REQ-006 WR  input  1  write request level, held by the initiator until the matching done pulse.
REQ-007 vec  input  1  burst select: 1 = VLEN-word vector access, 0 = single-word scalar access.
REQ-008 MemAddr  input  16  word address; only bits [ADDR_W-1:0] are used.
REQ-009 DataIn  input  16  scalar write data.
REQ-010 VDataIn  input  256  vector write data; word i occupies bits [16i+15:16i].
REQ-011 DataOut  output  16  scalar read data, registered.
REQ-012 VDataOut  output  256  vector read data, registered, same word packing as VDataIn.
REQ-013 Memdone  output  1  one-cycle pulse when a scalar access completes.
REQ-014 vld_done  output  1  one-cycle pulse when a vector read completes.
REQ-015 vst_done  output  1  one-cycle pulse when a vector write completes.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky flag, set when RD and WR are both sampled high in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, SRD, SWR, VRD, VWR and REL.
REQ-019 In IDLE, a request SHALL be accepted on an edge where exactly one of RD and WR is high.
- On acceptance, the FSM SHALL latch MemAddr, DataIn, VDataIn and vec.
- It SHALL then move to SRD, SWR, VRD or VWR as selected by RD/WR and vec.
REQ-020 Input changes after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-021 If RD and WR are both high in IDLE, the FSM SHALL stay in IDLE, set err, and perform no access.
REQ-022 Scalar read, accepted at edge k:
- At edge k+1, DataOut SHALL be loaded with mem[addr].
- Memdone SHALL be high for the cycle after edge k+1.
- The FSM SHALL then move to REL.
REQ-023 Scalar write, accepted at edge k:
- At edge k+1, mem[addr] SHALL be loaded with DataIn.
- Memdone SHALL pulse and the FSM SHALL move to REL, with the same timing as REQ-022.
REQ-024 Vector access, accepted at edge k:
- A 4-bit beat counter b SHALL be cleared on acceptance.
- Beat b SHALL occur at edge k+1+b, for b = 0..VLEN-1, one word per beat.
REQ-025 Vector beat address SHALL be (addr + b) mod 2^ADDR_W; wrap past the top word to word 0 SHALL be seamless.
REQ-026 Vector read:
- Each beat SHALL write mem[beat address] into word b of an internal buffer.
- At the last beat, VDataOut SHALL be loaded with the complete buffer.
- VDataOut SHALL hold its previous value during the burst.
REQ-027 Vector write: each beat SHALL write word b of the latched VDataIn into mem[beat address].
REQ-028 vld_done or vst_done SHALL be high for exactly the cycle after edge k+VLEN, after which the FSM SHALL move to REL.
REQ-029 In REL, the FSM SHALL stay until RD and WR are both low, then return to IDLE; no new request SHALL be accepted in REL.
REQ-030 Minimum spacing between two requests SHALL therefore be done pulse + one cycle with RD/WR low + one acceptance cycle.
REQ-031 At most one of Memdone, vld_done and vst_done SHALL be high in any cycle.

Reset
REQ-032 While rst = 0, the following SHALL hold:
- FSM in IDLE and beat counter at 0.
- DataOut, VDataOut and the internal buffer at 0.
- Memdone, vld_done, vst_done, busy and err at 0.
REQ-033 Memory array contents SHALL NOT be affected by reset.
REQ-034 Reset asserted mid-burst SHALL abort the burst immediately:
- Words already written SHALL remain in memory.
- No further memory writes SHALL occur.
- No done pulse SHALL be produced.
REQ-035 After rst is released, the first request SHALL be acceptable at the first rising edge.

Verification
REQ-036 Scalar write then read: WR, vec=0, MemAddr=0x0012, DataIn=0xBEEF -> Memdone 1 cycle after acceptance; RD same address -> DataOut=0xBEEF with Memdone.
REQ-037 Vector write then read: VWR at 0x0040 with word i = 0x1000+i -> vst_done 16 cycles after acceptance; VRD at 0x0040 -> VDataOut identical, vld_done 16 cycles after acceptance.
REQ-038 Wrap-around: vector write at 0x00F8 with ADDR_W=8 -> words 8..15 land at 0x00..0x07; scalar read of 0x0003 returns word 11.
REQ-039 Conflict: RD=WR=1 in IDLE -> err=1, no done pulse, memory unchanged; err stays 1 until reset.
REQ-040 Handshake: RD held high after vld_done -> busy stays 1 in REL and no second access occurs; RD low for one cycle, then high -> new read accepted.
REQ-041 Reset mid-burst: rst low after beat 5 of a vector write -> busy=0 at once, no vst_done; words 0..5 written, words 6..15 unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/response bundle between an initiator and mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int VLEN = 16
);
    logic                 RD;
    logic                 WR;
    logic                 vec;
    logic [15:0]          MemAddr;
    logic [15:0]          DataIn;
    logic [16*VLEN-1:0]   VDataIn;
    logic [15:0]          DataOut;
    logic [16*VLEN-1:0]   VDataOut;
    logic                 Memdone;
    logic                 vld_done;
    logic                 vst_done;
    logic                 busy;
    logic                 err;

    modport master (
        output RD, WR, vec, MemAddr, DataIn, VDataIn,
        input  DataOut, VDataOut, Memdone, vld_done, vst_done, busy, err
    );

    modport slave (
        input  RD, WR, vec, MemAddr, DataIn, VDataIn,
        output DataOut, VDataOut, Memdone, vld_done, vst_done, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : 16-bit word memory answering scalar and VLEN-word vector bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int VLEN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam int          VW        = 16 * VLEN;
    localparam logic [3:0]  LAST_BEAT = 4'(VLEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRD  = 3'd1,
        SWR  = 3'd2,
        VRD  = 3'd3,
        VWR  = 3'd4,
        REL  = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [15:0]         din;
    logic [VW-1:0]       vdin;
    logic [VW-1:0]       vbuf;
    logic [VW-1:0]       vout;
    logic [15:0]         dout;
    logic [3:0]          beat;
    logic                memdone;
    logic                vlddone;
    logic                vstdone;
    logic                err_flag;

    logic [15:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   beat_addr;
    logic [15:0]         rd_word;
    logic [15:0]         wr_word;
    logic                mem_we;
    logic [VW-1:0]       vbuf_next;

    // Scalar accesses run with beat = 0, so one address path serves both kinds.
    always_comb begin
        beat_addr = addr + ADDR_W'(beat);
        rd_word   = mem[beat_addr];
        wr_word   = (state == VWR) ? vdin[16*int'(beat) +: 16] : din;
        mem_we    = (state == SWR) || (state == VWR);
        vbuf_next = vbuf;
        vbuf_next[16*int'(beat) +: 16] = rd_word;
    end

    // Array has no reset; writes are gated by the FSM, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[beat_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            din      <= '0;
            vdin     <= '0;
            vbuf     <= '0;
            vout     <= '0;
            dout     <= '0;
            beat     <= '0;
            memdone  <= 1'b0;
            vlddone  <= 1'b0;
            vstdone  <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            memdone <= 1'b0;
            vlddone <= 1'b0;
            vstdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.RD && bus.WR) begin
                        err_flag <= 1'b1;
                    end else if (bus.RD || bus.WR) begin
                        addr  <= bus.MemAddr[ADDR_W-1:0];
                        din   <= bus.DataIn;
                        vdin  <= bus.VDataIn;
                        beat  <= '0;
                        state <= bus.RD ? (bus.vec ? VRD : SRD)
                                        : (bus.vec ? VWR : SWR);
                    end
                end
                SRD: begin
                    dout    <= rd_word;
                    memdone <= 1'b1;
                    state   <= REL;
                end
                SWR: begin
                    memdone <= 1'b1;
                    state   <= REL;
                end
                VRD: begin
                    vbuf <= vbuf_next;
                    beat <= beat + 4'd1;
                    if (beat == LAST_BEAT) begin
                        vout    <= vbuf_next;
                        vlddone <= 1'b1;
                        state   <= REL;
                    end
                end
                VWR: begin
                    beat <= beat + 4'd1;
                    if (beat == LAST_BEAT) begin
                        vstdone <= 1'b1;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (!bus.RD && !bus.WR) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DataOut  = dout;
    assign bus.VDataOut = vout;
    assign bus.Memdone  = memdone;
    assign bus.vld_done = vlddone;
    assign bus.vst_done = vstdone;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err_flag;

    generate
        if (ADDR_W < 16) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.MemAddr[15:ADDR_W];
        end
    endgenerate
endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Randomized bench for mem_responder against a word-array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;
    localparam int ADDR_W = 8;
    localparam int VLEN   = 16;
    localparam int VW     = 16 * VLEN;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.VLEN(VLEN)) bus ();

    mem_responder #(.ADDR_W(ADDR_W), .VLEN(VLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] ref_mem [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [VW-1:0] got,
                               input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < VLEN; i++) r[16*i +: 16] = 16'($urandom);
        return r;
    endfunction

    function automatic int word_index(input logic [15:0] a, input int i);
        return (int'(a[ADDR_W-1:0]) + i) % DEPTH;
    endfunction

    function automatic logic [VW-1:0] ref_vread(input logic [15:0] a);
        logic [VW-1:0] r;
        for (int i = 0; i < VLEN; i++) r[16*i +: 16] = ref_mem[word_index(a, i)];
        return r;
    endfunction

    task automatic ref_vwrite(input logic [15:0] a, input logic [VW-1:0] vd, input int nwords);
        for (int i = 0; i < nwords; i++) ref_mem[word_index(a, i)] = vd[16*i +: 16];
    endtask

    task automatic scramble_inputs();
        bus.vec     = 1'($urandom);
        bus.MemAddr = 16'($urandom);
        bus.DataIn  = 16'($urandom);
        bus.VDataIn = rand_vec();
    endtask

    task automatic check_quiet(input string tag, input logic exp_err);
        check_value(tag, VW'({bus.busy, bus.Memdone, bus.vld_done, bus.vst_done, bus.err}),
                    VW'({4'b0000, exp_err}));
    endtask

    // One complete request: raise, wait for the done pulse, optionally hold, release.
    task automatic access(input bit is_rd, input bit is_vec, input logic [15:0] a,
                          input logic [15:0] d, input logic [VW-1:0] vd,
                          input bit scramble, input int hold, input string tag);
        int            n;
        int            hold_bad;
        int            extra_bad;
        bit            seen;
        logic [VW-1:0] vout_before;
        logic [VW-1:0] exp_data;
        logic [2:0]    exp_done;

        vout_before = bus.VDataOut;
        bus.RD      = is_rd;
        bus.WR      = !is_rd;
        bus.vec     = is_vec;
        bus.MemAddr = a;
        bus.DataIn  = d;
        bus.VDataIn = vd;
        exp_data    = is_vec ? ref_vread(a) : VW'(ref_mem[word_index(a, 0)]);
        exp_done    = is_vec ? (is_rd ? 3'b010 : 3'b001) : 3'b100;
        tick();
        if (!is_rd) begin
            if (is_vec) ref_vwrite(a, vd, VLEN);
            else        ref_mem[word_index(a, 0)] = d;
        end

        n = 0;
        seen = 1'b0;
        hold_bad = 0;
        while (!seen && n < 40) begin
            if (scramble) scramble_inputs();
            tick();
            n++;
            if (bus.Memdone || bus.vld_done || bus.vst_done) seen = 1'b1;
            else if (bus.VDataOut !== vout_before) hold_bad++;
        end
        check_value({tag, "_latency"}, VW'(n), VW'(is_vec ? VLEN : 1));
        check_value({tag, "_done"}, VW'({bus.Memdone, bus.vld_done, bus.vst_done}), VW'(exp_done));
        check_value({tag, "_busy"}, VW'(bus.busy), VW'(1'b1));
        if (is_rd && is_vec) begin
            check_value({tag, "_vdata"}, bus.VDataOut, exp_data);
            check_value({tag, "_vhold"}, VW'(hold_bad), '0);
        end else if (is_rd) begin
            check_value({tag, "_data"}, VW'(bus.DataOut), exp_data);
        end

        extra_bad = 0;
        for (int h = 0; h < hold; h++) begin
            if (scramble) scramble_inputs();
            tick();
            if (!bus.busy || bus.Memdone || bus.vld_done || bus.vst_done) extra_bad++;
        end
        if (hold > 0) check_value({tag, "_rel_hold"}, VW'(extra_bad), '0);

        bus.RD = 1'b0;
        bus.WR = 1'b0;
        tick();
        check_value({tag, "_idle"},
                    VW'({bus.busy, bus.Memdone, bus.vld_done, bus.vst_done}), '0);
    endtask

    initial begin
        logic [VW-1:0] vd;
        logic [15:0]   a;
        int            op;

        bus.RD = 1'b0;
        bus.WR = 1'b0;
        bus.vec = 1'b0;
        bus.MemAddr = '0;
        bus.DataIn = '0;
        bus.VDataIn = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        check_quiet("reset_flags", 1'b0);
        check_value("reset_dout", VW'(bus.DataOut), '0);
        check_value("reset_vdout", bus.VDataOut, '0);
        rst = 1'b1;

        // Give every word a known value through vector writes.
        for (int j = 0; j < DEPTH / VLEN; j++)
            access(1'b0, 1'b1, 16'(j * VLEN), 16'h0, rand_vec(), 1'b0, 0, "fill");

        access(1'b0, 1'b0, 16'h0012, 16'hBEEF, '0, 1'b0, 0, "swr");
        access(1'b1, 1'b0, 16'h0012, 16'h0, '0, 1'b0, 0, "srd");
        check_value("srd_beef", VW'(bus.DataOut), VW'(16'hBEEF));

        for (int i = 0; i < VLEN; i++) vd[16*i +: 16] = 16'(16'h1000 + i);
        access(1'b0, 1'b1, 16'h0040, 16'h0, vd, 1'b0, 0, "vwr");
        access(1'b1, 1'b1, 16'h0040, 16'h0, '0, 1'b0, 0, "vrd");
        check_value("vrd_pattern", bus.VDataOut, vd);

        for (int i = 0; i < VLEN; i++) vd[16*i +: 16] = 16'(16'hA000 + i);
        access(1'b0, 1'b1, 16'h00F8, 16'h0, vd, 1'b0, 0, "wrap_wr");
        access(1'b1, 1'b0, 16'h0003, 16'h0, '0, 1'b0, 0, "wrap_rd");
        check_value("wrap_word11", VW'(bus.DataOut), VW'(16'hA00B));

        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 3));
            access(op[0], op[1], 16'($urandom), 16'($urandom), rand_vec(), 1'b1,
                   int'($urandom_range(0, 2)), "rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        // Held RD after a done pulse must not start a second access.
        access(1'b1, 1'b1, 16'h0080, 16'h0, '0, 1'b0, 3, "hs_vrd");
        access(1'b1, 1'b0, 16'h0085, 16'h0, '0, 1'b0, 0, "hs_next");

        a = 16'h00C4;
        bus.RD = 1'b1;
        bus.WR = 1'b1;
        bus.vec = 1'($urandom);
        bus.MemAddr = a;
        bus.DataIn = 16'h5A5A;
        bus.VDataIn = rand_vec();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("conflict", 1'b1);
        end
        bus.RD = 1'b0;
        bus.WR = 1'b0;
        tick();
        access(1'b1, 1'b1, a, 16'h0, '0, 1'b0, 0, "conflict_mem");
        for (int t = 0; t < 4; t++) begin
            op = int'($urandom_range(0, 3));
            access(op[0], op[1], 16'($urandom), 16'($urandom), rand_vec(), 1'b0, 0, "post_err");
        end
        check_value("err_sticky", VW'(bus.err), VW'(1'b1));

        // Reset lands after beat 5 of a vector write.
        a = 16'h0030;
        vd = rand_vec();
        bus.WR = 1'b1;
        bus.vec = 1'b1;
        bus.MemAddr = a;
        bus.VDataIn = vd;
        tick();
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check_quiet("rst_abort", 1'b0);
        check_value("rst_vdout", bus.VDataOut, '0);
        check_value("rst_dout", VW'(bus.DataOut), '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_quiet("rst_hold", 1'b0);
        end
        ref_vwrite(a, vd, 6);
        bus.WR = 1'b0;
        bus.vec = 1'b0;
        rst = 1'b1;
        access(1'b1, 1'b1, a, 16'h0, '0, 1'b0, 0, "rst_readback");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
